dcim_accumulator: RTL and testbench
===================================

Name: dcim_accumulator

Overview:
- Registered shift-and-add accumulator for the DCIM macro output path.
- Each enabled cycle it doubles the running sum and adds a new 27-bit partial sum: nout <= 2*nout + a.
- It recombines bit-serial partial products, MSB-first, into a wide result.
- Sits after the adder tree and before the macro output register and readout.

Parameters:
- A_WIDTH, 27, width of the input partial sum a.
- OUT_WIDTH, 51, width of the accumulated result (A_WIDTH + 24 shift steps of headroom).

Ports:
- clk  input  1  rising-edge clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset; clears the accumulator.
- a  input  A_WIDTH  partial sum to add this cycle; unsigned, zero-extended to OUT_WIDTH.
- acm_en  input  1  accumulate enable; when 0 the register holds its value.
- st  input  1  start/clear; when 1 the accumulator loads 0 and a is ignored.
- nout  output  OUT_WIDTH  accumulator register, driven directly from the flop with no combinational path from inputs.

Behaviour:
- Single register acc[OUT_WIDTH-1:0]; nout = acc.
- Priority at each rising edge of clk:
  - rst=1: acc <= 0.
  - else st=1: acc <= 0. This applies regardless of acm_en; a is ignored.
  - else acm_en=1: acc <= (acc << 1) + zero_ext(a).
  - else: acc <= acc (hold).
- Reset value of nout is 0. rst is sampled only on clk edges; there is no asynchronous clear.
- Latency: one cycle. Inputs sampled at edge N are visible on nout just after edge N.
- Arithmetic: unsigned, modulo 2^OUT_WIDTH. The MSB shifted out by <<1 and any carry out of the add are discarded (silent wrap, no saturation, no overflow flag).
- a is treated as unsigned. Any sign handling is upstream.
- st must be asserted for at least one cycle before a new accumulation sequence. The first enabled cycle after st yields nout = a.
- rst asserted mid-accumulation clears on the next edge. Accumulation resumes from 0 once rst=0 and acm_en=1.
- acm_en=0 with st=0 freezes nout indefinitely, with no dependence on a.
- X on a while acm_en=0 or st=1 must not propagate into nout.

Test Plan:
- Reset: rst=1 for 1+ cycles, then rst=0, st=1 -> nout=0 after each edge.
- Hold: st=0, acm_en=0, a=100 for 2 cycles -> nout stays 0.
- Accumulate: st=0, acm_en=1, a=10,20,30,0 on successive edges -> nout=10,40,110,220.
- Clear/restart: st=1, a=999 -> nout=0 next edge; then st=0, a=5 -> nout=5.
- Mid-operation reset: from nout=5 assert rst=1 with acm_en=1 -> nout=0 next edge; deassert, a=3 -> nout=3.
- Wrap: preload by accumulating a=2^27-1 for 25 cycles -> nout equals the modulo-2^51 value of the shift-add recurrence, with no X and no saturation.

Source files
------------

// File: rtl/dcim_accumulator.sv
// -----------------------------------------------------------------------------
// dcim_accumulator
//
// Registered shift-and-add accumulator on the DCIM macro output path. It sits
// between the adder tree and the macro output register. Bit-serial partial
// sums arrive MSB-first; each enabled cycle the running sum is doubled and the
// new partial sum is added:
//
//   nout <= 2*nout + a   (unsigned, modulo 2^OUT_WIDTH)
//
// Ports:
//   clk     in   1          rising-edge clock
//   rst     in   1          synchronous active-high reset, clears accumulator
//   a       in   A_WIDTH    unsigned partial sum, zero-extended to OUT_WIDTH
//   acm_en  in   1          accumulate enable; 0 holds the register
//   st      in   1          start/clear; loads 0 regardless of acm_en, a ignored
//   nout    out  OUT_WIDTH  accumulator value, straight from the flop
//
// Priority at each edge: rst > st > acm_en > hold.
// -----------------------------------------------------------------------------
module dcim_accumulator #(
  parameter int A_WIDTH   = 27,
  parameter int OUT_WIDTH = 51
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [A_WIDTH-1:0]   a,
  input  logic                 acm_en,
  input  logic                 st,
  output logic [OUT_WIDTH-1:0] nout
);

  localparam int EXT_W = OUT_WIDTH - A_WIDTH;

  logic [OUT_WIDTH-1:0] acc_q;
  logic [OUT_WIDTH-1:0] acc_d;

  // Doubling drops the MSB and the add discards its carry: the result wraps
  // silently modulo 2^OUT_WIDTH, with no saturation and no overflow flag.
  function automatic logic [OUT_WIDTH-1:0] shift_add(
    input logic [OUT_WIDTH-1:0] acc,
    input logic [A_WIDTH-1:0]   part
  );
    logic [OUT_WIDTH-1:0] dbl;
    logic [OUT_WIDTH-1:0] ext;
    dbl = {acc[OUT_WIDTH-2:0], 1'b0};
    ext = {{EXT_W{1'b0}}, part};
    return dbl + ext;
  endfunction

  // Next-state select. `a` only reaches acc_d on the accumulate branch, so an
  // unknown partial sum while holding or clearing cannot corrupt the result.
  always_comb begin
    acc_d = acc_q;
    if (st) begin
      acc_d = '0;
    end else if (acm_en) begin
      acc_d = shift_add(acc_q, a);
    end
  end

  // Stage boundary: accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign nout = acc_q;

endmodule

// File: tb/tb_dcim_accumulator.sv
module tb_dcim_accumulator;

  localparam int A_WIDTH   = 27;
  localparam int OUT_WIDTH = 51;
  localparam logic [63:0] MOD_MASK = (64'd1 << OUT_WIDTH) - 64'd1;

  logic                 clk;
  logic                 rst;
  logic [A_WIDTH-1:0]   a;
  logic                 acm_en;
  logic                 st;
  logic [OUT_WIDTH-1:0] nout;

  int n_checks;
  int n_pass;

  // Reference: the mathematical value of the accumulator, kept as a plain
  // integer and reduced modulo 2^OUT_WIDTH after every update.
  logic [63:0] model;

  dcim_accumulator #(
    .A_WIDTH  (A_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .acm_en(acm_en),
    .st    (st),
    .nout  (nout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Apply one cycle of inputs, advance the reference by the stated rules and
  // compare the registered output just after the edge.
  task automatic step(input logic r, input logic s, input logic e,
                      input logic [A_WIDTH-1:0] av, input string tag);
    @(negedge clk);
    rst    = r;
    st     = s;
    acm_en = e;
    a      = av;
    @(posedge clk);
    #1;
    if (r || s) begin
      model = 64'd0;
    end else if (e) begin
      model = (model * 64'd2 + {37'd0, av}) & MOD_MASK;
    end
    chk(tag, {13'd0, nout}, model);
  endtask

  initial begin
    logic [A_WIDTH-1:0] ra;
    logic               rr, rs, re;
    n_checks = 0;
    n_pass   = 0;
    model    = 64'd0;
    rst = 1'b1; st = 1'b0; acm_en = 1'b0; a = '0;

    // Reset, then start
    step(1'b1, 1'b0, 1'b0, 27'd0, "reset0");
    step(1'b1, 1'b0, 1'b1, 27'd77, "reset1");
    step(1'b0, 1'b1, 1'b0, 27'd0, "start");
    chk("reset_abs", {13'd0, nout}, 64'd0);

    // Hold with nonzero a
    step(1'b0, 1'b0, 1'b0, 27'd100, "hold0");
    step(1'b0, 1'b0, 1'b0, 27'd100, "hold1");

    // Accumulate 10,20,30,0 -> 10,40,110,220
    step(1'b0, 1'b0, 1'b1, 27'd10, "acc10");
    chk("acc_abs10", {13'd0, nout}, 64'd10);
    step(1'b0, 1'b0, 1'b1, 27'd20, "acc40");
    chk("acc_abs40", {13'd0, nout}, 64'd40);
    step(1'b0, 1'b0, 1'b1, 27'd30, "acc110");
    chk("acc_abs110", {13'd0, nout}, 64'd110);
    step(1'b0, 1'b0, 1'b1, 27'd0, "acc220");
    chk("acc_abs220", {13'd0, nout}, 64'd220);

    // Clear/restart; st wins over acm_en
    step(1'b0, 1'b1, 1'b1, 27'd999, "clear");
    step(1'b0, 1'b0, 1'b1, 27'd5, "restart");
    chk("restart_abs", {13'd0, nout}, 64'd5);

    // Mid-operation reset
    step(1'b1, 1'b0, 1'b1, 27'd7, "midrst");
    step(1'b0, 1'b0, 1'b1, 27'd3, "resume");
    chk("resume_abs", {13'd0, nout}, 64'd3);

    // X on a while holding or clearing must not reach nout
    step(1'b0, 1'b0, 1'b0, 'x, "x_hold");
    step(1'b0, 1'b1, 1'b1, 'x, "x_clear");

    // Wrap: 25 cycles of all-ones partial sums
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 1'b0, 1'b1, 27'h7FF_FFFF, "wrap");
    end
    step(1'b0, 1'b0, 1'b0, 27'h123_4567, "wrap_hold");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 31) == 0);
      rs = ($urandom_range(0, 15) == 0);
      re = ($urandom_range(0, 3) != 0);
      ra = A_WIDTH'($urandom);
      if (($urandom_range(0, 7) == 0)) ra = 27'h7FF_FFFF;
      if ((rs || !re) && ($urandom_range(0, 1) == 1)) ra = 'x;
      step(rr, rs, re, ra, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
